// File: rtl/xbar_mem_slave.sv
// xbar_mem_slave
// Memory responder for one crossbar slave port. Each accepted request gets
// a one-cycle ack and then a one-cycle resp. The ack and resp latencies are
// set by parameters. Reads return data from a word-addressed RAM.
// The block also keeps read/write completion counters and a sticky
// protocol-error flag for debug.
module xbar_mem_slave #(
    parameter int ADDR_W   = 30,
    parameter int DEPTH    = 1024,
    parameter int ACK_LAT  = 1,
    parameter int RESP_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              cmd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ack,
    output logic              resp,
    output logic [31:0]       rdata,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic              proto_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] ACK_INIT  = 4'(ACK_LAT - 1);
    localparam logic [3:0] RESP_INIT = 4'(RESP_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACKD,
        RESPD
    } state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               lat_cmd, lat_cmd_nxt;
    logic [IDX_W-1:0]   lat_idx, lat_idx_nxt;
    logic [31:0]        lat_wdata, lat_wdata_nxt;
    logic               ack_nxt, resp_nxt, proto_err_nxt;
    logic [31:0]        rdata_nxt;
    logic [CNT_W-1:0]   rd_cnt_nxt, wr_cnt_nxt;
    logic               mem_we;

    logic [31:0]        mem [DEPTH];

    // Address bits above the RAM index only alias, so they are folded away here
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

    // Next-state and next-output logic: IDLE accepts, ACKD counts down to ack, RESPD counts down to resp
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        lat_cmd_nxt   = lat_cmd;
        lat_idx_nxt   = lat_idx;
        lat_wdata_nxt = lat_wdata;
        ack_nxt       = 1'b0;
        resp_nxt      = 1'b0;
        rdata_nxt     = rdata;
        rd_cnt_nxt    = rd_cnt;
        wr_cnt_nxt    = wr_cnt;
        proto_err_nxt = proto_err;
        mem_we        = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    lat_cmd_nxt   = cmd;
                    lat_idx_nxt   = addr[IDX_W-1:0];
                    lat_wdata_nxt = wdata;
                    cnt_nxt       = ACK_INIT;
                    state_nxt     = ACKD;
                end
            end
            ACKD: begin
                if (req) begin
                    proto_err_nxt = 1'b1;
                end
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    ack_nxt   = 1'b1;
                    mem_we    = lat_cmd & ~rst;
                    cnt_nxt   = RESP_INIT;
                    state_nxt = RESPD;
                end
            end
            RESPD: begin
                if (req) begin
                    proto_err_nxt = 1'b1;
                end
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    resp_nxt  = 1'b1;
                    state_nxt = IDLE;
                    if (lat_cmd) begin
                        rdata_nxt  = 32'd0;
                        wr_cnt_nxt = wr_cnt + CNT_ONE;
                    end else begin
                        rdata_nxt  = mem[lat_idx];
                        rd_cnt_nxt = rd_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; synchronous reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_cmd   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= 32'd0;
            ack       <= 1'b0;
            resp      <= 1'b0;
            rdata     <= 32'd0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_cmd   <= lat_cmd_nxt;
            lat_idx   <= lat_idx_nxt;
            lat_wdata <= lat_wdata_nxt;
            ack       <= ack_nxt;
            resp      <= resp_nxt;
            rdata     <= rdata_nxt;
            rd_cnt    <= rd_cnt_nxt;
            wr_cnt    <= wr_cnt_nxt;
            proto_err <= proto_err_nxt;
        end
    end

    // RAM write happens on the ack edge; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

endmodule
